tt_um_adder_serial: RTL
=======================

TT_UM_ADDER_SERIAL -- requirements
Module: tt_um_adder_serial

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port start  input  1  request strobe, sampled on clk.
REQ-005 SHALL provide port mode  input  2  00 add, 01 accumulate, 10 subtract, 11 clear accumulator.
REQ-006 SHALL provide port a  input  WIDTH  operand A.
REQ-007 SHALL provide port b  input  WIDTH  operand B; ignored in modes 01 and 11.
REQ-008 SHALL provide port cin  input  1  carry-in; ignored in modes 10 and 11.
REQ-009 SHALL provide port busy  output  1  high while an operation is in progress.
REQ-010 SHALL provide port done  output  1  one-cycle completion pulse.
REQ-011 SHALL provide port sum  output  WIDTH+1  last result, {carry, WIDTH result bits}.
REQ-012 SHALL provide port acc  output  WIDTH+1  accumulator register.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and RUN, plus a bit counter of ceil(log2(WIDTH)) bits.
REQ-014 In IDLE, start=1 at edge k SHALL latch a, b (or acc[WIDTH-1:0] in mode 01), cin and mode, clear counter, enter RUN, set busy=1.
REQ-015 In RUN, edge k+1+i SHALL compute result bit i with a single full adder and a registered carry, i = 0..WIDTH-1, LSB first.
REQ-016 At edge k+WIDTH SHALL load sum with {carry, result}, assert done for exactly one cycle, clear busy and return to IDLE; latency start-to-done = WIDTH cycles.
REQ-017 In mode 01, the same edge SHALL also load acc with the new sum; sum[WIDTH] is the overflow carry.
REQ-018 Mode 11 with start in IDLE SHALL clear acc at edge k, set sum to 0, pulse done in the following cycle, and SHALL NOT enter RUN or raise busy.
REQ-019 start while busy=1 SHALL be ignored; no queuing; latched operands unchanged.
REQ-020 start during the done cycle SHALL be accepted (FSM is already IDLE).
REQ-021 Input changes on a, b, cin, mode during RUN SHALL NOT affect the running result.
REQ-022 sum and acc SHALL hold their values between operations; done SHALL be 0 except for the completion pulse.
REQ-023 Accumulation SHALL wrap modulo 2^WIDTH: the next accumulate uses acc[WIDTH-1:0] only; the carry is reported and not fed back.

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE, counter 0, busy=0, done=0, sum=0, acc=0.
REQ-025 Reset during RUN SHALL abort the operation with no done pulse and no sum/acc update.
REQ-026 First start SHALL be sampled on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro ADDER_SUB_EN defined: mode 10 SHALL compute a + ~b + 1 serially; sum[WIDTH]=1 means no borrow (a >= b).
REQ-028 Macro ADDER_SUB_EN undefined: mode 10 SHALL behave exactly as mode 00, including cin use, and no inverter/forced-carry logic SHALL be present.

Verification (WIDTH=4)
REQ-029 Start, mode 00, a=5, b=9, cin=0 -> busy 4 cycles, done pulse, sum=0_1110 (14).
REQ-030 Mode 00, a=15, b=15, cin=1 -> sum=1_1111 (31); start re-asserted 2 cycles later while busy -> ignored, exactly one done.
REQ-031 Mode 11 then mode 01 a=3, then mode 01 a=7 -> acc=0_1010 (10); then mode 01 a=8 -> acc=1_0010, next accumulate uses 0010.
REQ-032 ADDER_SUB_EN: mode 10 a=9, b=5 -> sum=1_0100; a=5, b=9 -> sum=0_1100. Without macro: a=9, b=5, cin=0 -> sum=0_1110.
REQ-033 rst_n pulsed low 2 cycles after start -> busy=0, done never pulses, sum=0, acc=0 immediately; next start completes normally.
REQ-034 Start asserted in the done cycle with a=1, b=2 -> second done exactly WIDTH cycles later, sum=0_0011.

Source files
------------

// File: rtl/tt_um_adder_serial.sv
// rtl/tt_um_adder_serial.sv - bit-serial adder/accumulator, one full-adder bit per clock, LSB first.
// Optional macro ADDER_SUB_EN turns mode 10 into serial subtract (a + ~b + 1).
module tt_um_adder_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic [WIDTH:0]   acc
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_is_acc;
  logic             r_done;
  logic [WIDTH:0]   r_sum;
  logic [WIDTH:0]   r_acc;

  logic             w_s;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_b_op;
  logic             w_cin_op;

  assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_cout = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Operand B and carry-in as latched at start; accumulate feeds back only the low WIDTH bits.
  always_comb begin
    w_b_op   = b;
    w_cin_op = cin;
    if (mode == 2'b01) begin
      w_b_op = r_acc[WIDTH-1:0];
    end
`ifdef ADDER_SUB_EN
    if (mode == 2'b10) begin
      w_b_op   = ~b;
      w_cin_op = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start && (mode != 2'b11)) begin
          w_next = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_carry  <= 1'b0;
      r_is_acc <= 1'b0;
      r_done   <= 1'b0;
      r_sum    <= '0;
      r_acc    <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          if (mode == 2'b11) begin
            r_acc  <= '0;
            r_sum  <= '0;
            r_done <= 1'b1;
          end else begin
            r_a      <= a;
            r_b      <= w_b_op;
            r_carry  <= w_cin_op;
            r_is_acc <= (mode == 2'b01);
            r_cnt    <= '0;
          end
        end
      end else begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_carry <= w_cout;
        r_res   <= {w_s, r_res[WIDTH-1:1]};
        r_cnt   <= r_cnt + CW'(1);
        // Final bit: the current full-adder output completes the word.
        if (w_last) begin
          r_sum  <= {w_cout, w_s, r_res[WIDTH-1:1]};
          r_done <= 1'b1;
          if (r_is_acc) begin
            r_acc <= {w_cout, w_s, r_res[WIDTH-1:1]};
          end
        end
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign sum  = r_sum;
  assign acc  = r_acc;

endmodule
